input_memory_ctrl: RTL
======================

INPUT_MEMORY_CTRL -- requirements
Module: input_memory_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning the byte width of stream and memory data.
REQ-002 SHALL have parameter ADDR_W, default 6, meaning the memory pointer width (64 locations).
REQ-003 SHALL have port clk  input  1  single clock for all state.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port start  input  1  begins a load/replay job when sampled high in IDLE.
REQ-006 SHALL have port cfg_len  input  ADDR_W  frame length in bytes, legal 1..63, sampled on accepted start.
REQ-007 SHALL have port cfg_passes  input  4  replay count, sampled on accepted start; 0 treated as 1.
REQ-008 SHALL have port in_valid  input  1  upstream byte valid.
REQ-009 SHALL have port in_data  input  DATA_W  upstream byte.
REQ-010 SHALL have port in_ready  output  1  controller accepts the byte this cycle.
REQ-011 SHALL have port out_valid  output  1  downstream byte valid.
REQ-012 SHALL have port out_data  output  DATA_W  downstream byte.
REQ-013 SHALL have port out_last  output  1  marks the final byte of each pass.
REQ-014 SHALL have port out_ready  input  1  downstream accepts the byte.
REQ-015 SHALL have port mem_wr_ptr  output  ADDR_W  memory write pointer.
REQ-016 SHALL have port mem_data_in  output  DATA_W  memory write data.
REQ-017 SHALL have port mem_rd_ptr  output  ADDR_W  memory read pointer.
REQ-018 SHALL have port mem_data_out  input  DATA_W  registered memory read data, valid one cycle after mem_rd_ptr.
REQ-019 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-020 SHALL have port done  output  1  one-cycle pulse at job completion.

Function
REQ-021 SHALL implement FSM states IDLE, LOAD, READ, DONE.
REQ-022 IDLE: start=1 with cfg_len!=0 -> LOAD; start with cfg_len=0 ignored; start in any other state ignored.
REQ-023 The memory writes every clock, so address 63 SHALL be the park slot: mem_wr_ptr=63 whenever no byte is accepted; usable capacity is 63 bytes.
REQ-024 mem_data_in SHALL equal in_data combinationally in all states.
REQ-025 LOAD: in_ready=1; each in_valid&in_ready beat writes address wr_cnt (0,1,2,...), wr_cnt increments; in_ready=0 in all other states.
REQ-026 LOAD -> READ on the clock edge that accepts byte number cfg_len.
REQ-027 READ: issue reads at addresses 0..len-1, repeated passes times; one read issued per cycle while skid-buffer occupancy plus in-flight reads < 2.
REQ-028 A 2-entry skid buffer SHALL hold returned data so no byte is lost or duplicated under any out_ready pattern.
REQ-029 First out_valid SHALL appear the cycle after the first READ cycle; with out_ready held high, throughput is one byte per cycle with no bubbles across pass boundaries.
REQ-030 out_last=1 with the byte read from address len-1 of every pass.
REQ-031 out_valid/out_data/out_last SHALL stay stable while out_valid=1 and out_ready=0.
REQ-032 READ -> DONE when the final byte of the final pass is accepted; DONE lasts one cycle with done=1, then IDLE.
REQ-033 mem_rd_ptr SHALL hold its last value when no read is issued.

Reset
REQ-034 rst=1 SHALL immediately force IDLE, counters 0, skid buffer empty, in_ready=0, out_valid=0, out_last=0, done=0, busy=0, mem_wr_ptr=63, mem_rd_ptr=0.
REQ-035 Reset mid-LOAD or mid-READ SHALL abort the job with no done pulse; memory contents are not cleared and are not relied upon.

Verification
REQ-036 cfg_len=4, passes=1, bytes 0x11,0x22,0x33,0x44 back-to-back, out_ready=1 -> out 0x11..0x44 consecutive, out_last on 0x44, done 1 cycle later.
REQ-037 cfg_len=3, passes=2, out_ready=1 -> 6 contiguous beats A,B,C,A,B,C, out_last on both C beats, single done.
REQ-038 cfg_len=8, out_ready toggled randomly -> exact 8-byte order, no drop/duplication, data stable while stalled.
REQ-039 Gaps in in_valid during LOAD -> mem_wr_ptr=63 in gap cycles; only addresses 0..len-1 written with the frame bytes.
REQ-040 start with cfg_len=0 -> stays IDLE, busy=0; start during READ -> ignored, job unchanged.
REQ-041 rst pulsed mid-READ after 2 of 5 bytes -> all outputs at reset values immediately, no done; a new job afterwards completes normally.

Source files
------------

// File: rtl/input_memory_ctrl_if.sv
// Signal bundle of the frame load/replay controller: upstream stream, downstream stream,
// memory ports and job control/status. master = surrounding system, slave = controller.
interface input_memory_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6
);
  logic              start;
  logic [ADDR_W-1:0] cfg_len;
  logic [3:0]        cfg_passes;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              out_ready;
  logic [ADDR_W-1:0] mem_wr_ptr;
  logic [DATA_W-1:0] mem_data_in;
  logic [ADDR_W-1:0] mem_rd_ptr;
  logic [DATA_W-1:0] mem_data_out;
  logic              busy;
  logic              done;

  modport master (
    output start, cfg_len, cfg_passes, in_valid, in_data, out_ready, mem_data_out,
    input  in_ready, out_valid, out_data, out_last, mem_wr_ptr, mem_data_in, mem_rd_ptr,
           busy, done
  );

  modport slave (
    input  start, cfg_len, cfg_passes, in_valid, in_data, out_ready, mem_data_out,
    output in_ready, out_valid, out_data, out_last, mem_wr_ptr, mem_data_in, mem_rd_ptr,
           busy, done
  );
endinterface

// File: rtl/input_memory_ctrl.sv
// Loads one frame into an external 1-cycle-latency memory, then replays it cfg_passes times;
// first byte one cycle after READ entry, 2-entry skid buffer absorbs any out_ready stall pattern.
module input_memory_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input_memory_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, LOAD, READ, DONE} state_t;

  localparam logic [ADDR_W-1:0] PARK  = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] ONE_A = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] len_q, wr_cnt_q, rd_addr_q, rd_ptr_q;
  logic [3:0]        passes_q, rd_pass_q, out_pass_q;
  logic              rd_all_q, inf_q, inf_last_q;
  logic [DATA_W-1:0] sk_dat_q [2];
  logic [1:0]        sk_last_q;
  logic [1:0]        sk_cnt_q;
  logic              sk_head_q;

  logic in_ready_c, busy_c, done_c;
  logic start_ok, in_fire, load_end;
  logic issue, issue_last, out_vld_c, out_fire, push, pop_sk, wr_idx, final_beat;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_ok)   state_d = LOAD;
      LOAD:    if (load_end)   state_d = READ;
      READ:    if (final_beat) state_d = DONE;
      default:                 state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    in_ready_c = 1'b0;
    busy_c     = 1'b1;
    done_c     = 1'b0;
    case (state_q)
      IDLE:    busy_c     = 1'b0;
      LOAD:    in_ready_c = 1'b1;
      DONE:    done_c     = 1'b1;
      default: ;
    endcase
  end

  assign start_ok = (state_q == IDLE) && bus.start && (bus.cfg_len != '0);
  assign in_fire  = bus.in_valid && in_ready_c;
  assign load_end = in_fire && (wr_cnt_q == len_q - ONE_A);

  // Skid occupancy plus the one possible in-flight read must stay below two.
  assign issue      = (state_q == READ) && !rd_all_q &&
                      ((sk_cnt_q == 2'd0) || ((sk_cnt_q == 2'd1) && !inf_q));
  assign issue_last = (rd_addr_q == len_q - ONE_A);

  assign out_vld_c  = (sk_cnt_q != 2'd0) || inf_q;
  assign out_fire   = out_vld_c && bus.out_ready;
  assign pop_sk     = out_fire && (sk_cnt_q != 2'd0);
  assign push       = inf_q && !((sk_cnt_q == 2'd0) && bus.out_ready);
  assign wr_idx     = sk_head_q ^ (sk_cnt_q == 2'd1);
  assign final_beat = out_fire && bus.out_last && (out_pass_q == passes_q - 4'd1);

  assign bus.in_ready    = in_ready_c;
  assign bus.busy        = busy_c;
  assign bus.done        = done_c;
  assign bus.mem_data_in = bus.in_data;
  assign bus.mem_wr_ptr  = in_fire ? wr_cnt_q : PARK;
  assign bus.mem_rd_ptr  = issue ? rd_addr_q : rd_ptr_q;
  assign bus.out_valid   = out_vld_c;
  // With the skid empty, freshly returned memory data bypasses straight to the output.
  assign bus.out_data    = (sk_cnt_q != 2'd0) ? sk_dat_q[sk_head_q] : bus.mem_data_out;
  assign bus.out_last    = (sk_cnt_q != 2'd0) ? sk_last_q[sk_head_q] : (inf_q && inf_last_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q      <= '0;
      passes_q   <= '0;
      wr_cnt_q   <= '0;
      rd_addr_q  <= '0;
      rd_ptr_q   <= '0;
      rd_pass_q  <= '0;
      out_pass_q <= '0;
      rd_all_q   <= 1'b0;
      inf_q      <= 1'b0;
      inf_last_q <= 1'b0;
      sk_dat_q[0] <= '0;
      sk_dat_q[1] <= '0;
      sk_last_q  <= '0;
      sk_cnt_q   <= '0;
      sk_head_q  <= 1'b0;
    end else begin
      if (start_ok) begin
        len_q      <= bus.cfg_len;
        passes_q   <= (bus.cfg_passes == 4'd0) ? 4'd1 : bus.cfg_passes;
        wr_cnt_q   <= '0;
        rd_addr_q  <= '0;
        rd_pass_q  <= '0;
        out_pass_q <= '0;
        rd_all_q   <= 1'b0;
        sk_cnt_q   <= '0;
        sk_head_q  <= 1'b0;
      end
      if (in_fire) wr_cnt_q <= wr_cnt_q + ONE_A;

      if (issue) begin
        rd_ptr_q <= rd_addr_q;
        if (issue_last) begin
          rd_addr_q <= '0;
          if (rd_pass_q == passes_q - 4'd1) rd_all_q  <= 1'b1;
          else                              rd_pass_q <= rd_pass_q + 4'd1;
        end else begin
          rd_addr_q <= rd_addr_q + ONE_A;
        end
      end
      inf_q      <= issue;
      inf_last_q <= issue && issue_last;

      if (push) begin
        sk_dat_q[wr_idx]  <= bus.mem_data_out;
        sk_last_q[wr_idx] <= inf_last_q;
      end
      if (pop_sk) sk_head_q <= ~sk_head_q;
      if (push && !pop_sk)      sk_cnt_q <= sk_cnt_q + 2'd1;
      else if (!push && pop_sk) sk_cnt_q <= sk_cnt_q - 2'd1;

      if (out_fire && bus.out_last) out_pass_q <= out_pass_q + 4'd1;
    end
  end

endmodule
